// File: rtl/paint_draw_fsm_pkg.sv
// Shared definitions for the paint drawing controller.
// - state_t : controller state encoding, also exported on the debug port
// - MODE_*  : mode switch codes (2'b10 is reserved and behaves as a point)
package paint_pkg;

  typedef enum logic [4:0] {
    S_WAIT    = 5'd0,
    S_LOAD_X  = 5'd1,
    S_LOAD_Y  = 5'd2,
    S_WAIT_2  = 5'd3,
    S_LOAD_X2 = 5'd4,
    S_LOAD_Y2 = 5'd5,
    S_DRAW    = 5'd6
  } state_t;

  localparam logic [1:0] MODE_POINT = 2'b00;
  localparam logic [1:0] MODE_RECT  = 2'b01;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

endpackage

// File: rtl/paint_draw_fsm_if.sv
// Key/switch inputs and the VGA adapter pixel port of the paint controller.
// master : the drawing controller (reads go/mode/coord_in/colour_in,
//          drives x_out/y_out/colour_out/plot/busy/done)
// slave  : the environment (keys, switches and VGA adapter)
// Pixel port semantics: every cycle with plot high is exactly one pixel
// write of colour_out at (x_out, y_out); there is no back-pressure, the
// adapter accepts one pixel per cycle. done marks the final pixel of a
// command and is only ever high together with plot.
interface paint_draw_fsm_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) ();

  logic                go;
  logic [1:0]          mode;
  logic [X_W-1:0]      coord_in;
  logic [COLOUR_W-1:0] colour_in;
  logic [X_W-1:0]      x_out;
  logic [Y_W-1:0]      y_out;
  logic [COLOUR_W-1:0] colour_out;
  logic                plot;
  logic                busy;
  logic                done;

  modport master (
    input  go, mode, coord_in, colour_in,
    output x_out, y_out, colour_out, plot, busy, done
  );

  modport slave (
    output go, mode, coord_in, colour_in,
    input  x_out, y_out, colour_out, plot, busy, done
  );

endinterface

// File: rtl/paint_draw_fsm_rect_sweep.sv
// Raster sweep over the rectangle spanned by two corners.
// Ports:
//   Clock, Reset   : clock, synchronous active-high reset
//   start          : load corners (any order) and begin at (xmin, ymin)
//   x1, y1, x2, y2 : corner coordinates, sampled only when start is high
//   xc, yc         : current pixel; hold the final pixel after the sweep
//   last           : high while (xc, yc) is the final pixel of the sweep
module rect_sweep #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           start,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y1,
  input  logic [X_W-1:0] x2,
  input  logic [Y_W-1:0] y2,
  output logic [X_W-1:0] xc,
  output logic [Y_W-1:0] yc,
  output logic           last
);

  logic [X_W-1:0] xmin, xmax;
  logic [Y_W-1:0] ymin, ymax;
  logic           active;

  assign last = active && (xc == xmax) && (yc == ymax);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      xmin   <= '0;
      xmax   <= '0;
      ymin   <= '0;
      ymax   <= '0;
      xc     <= '0;
      yc     <= '0;
      active <= 1'b0;
    end else if (start) begin
      xmin   <= (x1 < x2) ? x1 : x2;
      xmax   <= (x1 < x2) ? x2 : x1;
      ymin   <= (y1 < y2) ? y1 : y2;
      ymax   <= (y1 < y2) ? y2 : y1;
      xc     <= (x1 < x2) ? x1 : x2;
      yc     <= (y1 < y2) ? y1 : y2;
      active <= 1'b1;
    end else if (active) begin
      // The counters stop on the final pixel so the pixel port keeps
      // showing it once the controller is idle again.
      if (last) begin
        active <= 1'b0;
      end else if (xc == xmax) begin
        xc <= xmin;
        yc <= yc + 1'b1;
      end else begin
        xc <= xc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/paint_draw_fsm.sv
// Paint controller: captures corners with a debounced go key, then writes
// one pixel per clock to the VGA adapter (point, filled rectangle, clear).
// Ports:
//   Clock, Reset : clock, synchronous active-high reset
//   bus          : key/switch inputs and pixel port (master side)
//   state_dbg    : current controller state
module paint_draw_fsm
  import paint_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int MAX_X    = 159,
  parameter int MAX_Y    = 119
) (
  input  logic             Clock,
  input  logic             Reset,
  paint_draw_fsm_if.master bus,
  output state_t           state_dbg
);

  localparam logic [X_W-1:0] MAX_XV = X_W'(MAX_X);
  localparam logic [Y_W-1:0] MAX_YV = Y_W'(MAX_Y);

  function automatic logic [X_W-1:0] sat_x(input logic [X_W-1:0] v);
    return (v > MAX_XV) ? MAX_XV : v;
  endfunction

  function automatic logic [Y_W-1:0] sat_y(input logic [Y_W-1:0] v);
    return (v > MAX_YV) ? MAX_YV : v;
  endfunction

  state_t              state_q, state_d;
  logic                go_q;
  logic                go_rise;
  logic [1:0]          mode_r, mode_d;
  logic [COLOUR_W-1:0] colour_r, colour_d;
  logic [X_W-1:0]      x1_r, x1_d, x2_r, x2_d;
  logic [Y_W-1:0]      y1_r, y1_d, y2_r, y2_d;
  logic                start;
  logic [X_W-1:0]      xc;
  logic [Y_W-1:0]      yc;
  logic                last;

  assign go_rise = bus.go & ~go_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_WAIT;
      go_q     <= 1'b1;  // a key held through reset must not advance
      mode_r   <= MODE_POINT;
      colour_r <= '0;
      x1_r     <= '0;
      y1_r     <= '0;
      x2_r     <= '0;
      y2_r     <= '0;
    end else begin
      state_q  <= state_d;
      go_q     <= bus.go;
      mode_r   <= mode_d;
      colour_r <= colour_d;
      x1_r     <= x1_d;
      y1_r     <= y1_d;
      x2_r     <= x2_d;
      y2_r     <= y2_d;
    end
  end

  // The sweep is started from the next-state corner values, so corners
  // captured in the same cycle that enters DRAW are already included.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_r;
    colour_d = colour_r;
    x1_d     = x1_r;
    y1_d     = y1_r;
    x2_d     = x2_r;
    y2_d     = y2_r;
    start    = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (go_rise) begin
          mode_d   = bus.mode;
          colour_d = bus.colour_in;
          if (bus.mode == MODE_CLEAR) begin
            colour_d = '0;
            x1_d     = '0;
            y1_d     = '0;
            x2_d     = MAX_XV;
            y2_d     = MAX_YV;
            start    = 1'b1;
            state_d  = S_DRAW;
          end else begin
            state_d  = S_LOAD_X;
          end
        end
      end
      S_LOAD_X: begin
        if (go_rise) begin
          x1_d    = sat_x(bus.coord_in);
          state_d = S_LOAD_Y;
        end
      end
      S_LOAD_Y: begin
        if (go_rise) begin
          y1_d = sat_y(bus.coord_in[Y_W-1:0]);
          if (mode_r == MODE_RECT) begin
            state_d = S_WAIT_2;
          end else begin
            x2_d    = x1_r;
            y2_d    = sat_y(bus.coord_in[Y_W-1:0]);
            start   = 1'b1;
            state_d = S_DRAW;
          end
        end
      end
      S_WAIT_2: begin
        if (go_rise) state_d = S_LOAD_X2;
      end
      S_LOAD_X2: begin
        if (go_rise) begin
          x2_d    = sat_x(bus.coord_in);
          state_d = S_LOAD_Y2;
        end
      end
      S_LOAD_Y2: begin
        if (go_rise) begin
          y2_d    = sat_y(bus.coord_in[Y_W-1:0]);
          start   = 1'b1;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        if (last) state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  rect_sweep #(
    .X_W(X_W),
    .Y_W(Y_W)
  ) u_sweep (
    .Clock (Clock),
    .Reset (Reset),
    .start (start),
    .x1    (x1_d),
    .y1    (y1_d),
    .x2    (x2_d),
    .y2    (y2_d),
    .xc    (xc),
    .yc    (yc),
    .last  (last)
  );

  assign bus.plot       = (state_q == S_DRAW);
  assign bus.done       = (state_q == S_DRAW) && last;
  assign bus.busy       = (state_q != S_WAIT);
  assign bus.x_out      = xc;
  assign bus.y_out      = yc;
  assign bus.colour_out = colour_r;
  assign state_dbg      = state_q;

endmodule
